// File: rtl/perf_monitor_if.sv
// perf_monitor_if: core event strobes in, counters and CPI result out.
interface perf_monitor_if #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 8
);
   logic              instr_retire;
   logic              stall;
   logic              clear;
   logic              snapshot_req;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  instr_count;
   logic [CNT_W-1:0]  stall_count;
   logic              overflow;
   logic              busy;
   logic [CNT_W-1:0]  cpi_int;
   logic [FRAC_W-1:0] cpi_frac;
   logic              cpi_valid;
   logic              div_zero;
   modport master (
      output instr_retire, stall, clear, snapshot_req,
      input  cycle_count, instr_count, stall_count, overflow,
      input  busy, cpi_int, cpi_frac, cpi_valid, div_zero
   );
   modport slave (
      input  instr_retire, stall, clear, snapshot_req,
      output cycle_count, instr_count, stall_count, overflow,
      output busy, cpi_int, cpi_frac, cpi_valid, div_zero
   );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: saturating cycle/retire/stall counters plus a restoring-divider CPI snapshot.
module perf_monitor #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 8
) (
   input logic           clk,
   input logic           pc_rst,
   perf_monitor_if.slave pm
);
   localparam int Q  = CNT_W + FRAC_W;
   localparam int CW = $clog2(Q);
   localparam logic [CNT_W-1:0] MAX = '1;
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t           state, state_nxt;
   logic             pend;
   logic             take;
   logic [CNT_W-1:0] snap_cyc, snap_ins;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic [Q-1:0]     dq, dq_nxt;
   logic [CW-1:0]    cnt;
   logic [CNT_W:0]   t, diff;
   logic             ge;
   // pend marks the IDLE cycle after a capture, where the latched divisor is inspected
   assign take         = state == IDLE && !pend && pm.snapshot_req;
   assign pm.busy      = state == DIV;
   assign pm.cpi_valid = state == DONE;
   always_ff @(posedge clk or posedge pc_rst)
      if (pc_rst) begin
         pm.cycle_count <= '0;
         pm.instr_count <= '0;
         pm.stall_count <= '0;
         pm.overflow    <= 1'b0;
      end else if (pm.clear) begin
         pm.cycle_count <= '0;
         pm.instr_count <= '0;
         pm.stall_count <= '0;
         pm.overflow    <= 1'b0;
      end else begin
         pm.cycle_count <= pm.cycle_count + CNT_W'(pm.cycle_count != MAX);
         pm.instr_count <= pm.instr_count + CNT_W'(pm.instr_retire && pm.instr_count != MAX);
         pm.stall_count <= pm.stall_count + CNT_W'(pm.stall && pm.stall_count != MAX);
         pm.overflow    <= pm.overflow || pm.cycle_count == MAX ||
                           (pm.instr_retire && pm.instr_count == MAX) ||
                           (pm.stall && pm.stall_count == MAX);
      end
   // dq holds the shifting dividend and collects quotient bits from the bottom
   always_comb begin
      t       = {rem, dq[Q-1]};
      diff    = t - {1'b0, snap_ins};
      ge      = t >= {1'b0, snap_ins};
      rem_nxt = ge ? diff[CNT_W-1:0] : t[CNT_W-1:0];
      dq_nxt  = {dq[Q-2:0], ge};
   end
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = !pend ? IDLE : (snap_ins == '0 ? DONE : DIV);
         DIV:     state_nxt = cnt == CW'(Q-1) ? DONE : DIV;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge pc_rst)
      if (pc_rst) begin
         state       <= IDLE;
         pend        <= 1'b0;
         snap_cyc    <= '0;
         snap_ins    <= '0;
         rem         <= '0;
         dq          <= '0;
         cnt         <= '0;
         pm.cpi_int  <= '0;
         pm.cpi_frac <= '0;
         pm.div_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= take;
         if (take) begin
            snap_cyc <= pm.cycle_count;
            snap_ins <= pm.instr_count;
         end
         if (state == IDLE && pend) begin
            rem <= '0;
            dq  <= {snap_cyc, FRAC_W'(0)};
            cnt <= '0;
            if (snap_ins == '0) begin
               pm.cpi_int  <= '1;
               pm.cpi_frac <= '1;
               pm.div_zero <= 1'b1;
            end
         end
         if (state == DIV) begin
            rem <= rem_nxt;
            dq  <= dq_nxt;
            cnt <= cnt + CW'(1);
            if (state_nxt == DONE) begin
               pm.cpi_int  <= dq_nxt[Q-1:FRAC_W];
               pm.cpi_frac <= dq_nxt[FRAC_W-1:0];
               pm.div_zero <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized stimulus against a count-level reference model with a CPI scoreboard.
`timescale 1ns/1ps
module tb_perf_monitor;
   localparam int Q = 40;
   localparam longint MAX = 64'hFFFF_FFFF;
   typedef struct {longint ci; longint cf; bit dz; int en; int bsy;} exp_t;
   logic clk = 0;
   logic pc_rst = 0;
   perf_monitor_if #(.CNT_W(32), .FRAC_W(8)) bus ();
   perf_monitor_if #(.CNT_W(4), .FRAC_W(8)) bus4 ();
   perf_monitor #(.CNT_W(32), .FRAC_W(8)) dut (.clk(clk), .pc_rst(pc_rst), .pm(bus.slave));
   perf_monitor #(.CNT_W(4), .FRAC_W(8)) dut4 (.clk(clk), .pc_rst(pc_rst), .pm(bus4.slave));
   always #10 clk = ~clk;
   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;
   exp_t   q[$];
   exp_t   mx;
   int     checks = 0, errors = 0;
   longint m_cyc = 0, m_ins = 0, m_stl = 0;
   bit     m_ovf = 0;
   int     busy_until = -10;
   int     busy_run = 0;
   bit     mon_en = 0;
   longint l_ci = 0, l_cf = 0;
   bit     l_dz = 0;
   task automatic chk(input string n, input longint a, input longint e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, a, e);
      end
   endtask
   // One clock of stimulus; the model decides acceptance and the CPI from plain counts.
   task automatic step(input bit r, input bit s, input bit c, input bit sn);
      int e;
      exp_t x;
      longint qt;
      bus.instr_retire = r;
      bus.stall = s;
      bus.clear = c;
      bus.snapshot_req = sn;
      e = ecnt + 1;
      if (sn && e > busy_until) begin
         if (m_ins == 0) x = '{MAX, 255, 1'b1, e + 1, 0};
         else begin
            qt = (m_cyc * 256) / m_ins;
            x = '{qt / 256, qt % 256, 1'b0, e + Q + 1, Q};
         end
         q.push_back(x);
         busy_until = x.en + 1;
      end
      @(posedge clk);
      if (c) begin
         m_cyc = 0; m_ins = 0; m_stl = 0; m_ovf = 0;
      end else begin
         m_ovf = m_ovf | (m_cyc == MAX) | (r && m_ins == MAX) | (s && m_stl == MAX);
         m_cyc = (m_cyc + 1 > MAX) ? MAX : m_cyc + 1;
         if (r) m_ins = (m_ins + 1 > MAX) ? MAX : m_ins + 1;
         if (s) m_stl = (m_stl + 1 > MAX) ? MAX : m_stl + 1;
      end
      #1;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         step(0, 0, 0, 0);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
   endtask
   always @(negedge clk) if (mon_en) begin
      chk("cycle_count", bus.cycle_count, m_cyc);
      chk("instr_count", bus.instr_count, m_ins);
      chk("stall_count", bus.stall_count, m_stl);
      chk("overflow", bus.overflow, m_ovf);
      if (bus.cpi_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cpi_valid unexpected at edge %0d got 1 expected 0", ecnt);
         end else begin
            mx = q.pop_front();
            chk("cpi_int", bus.cpi_int, mx.ci);
            chk("cpi_frac", bus.cpi_frac, mx.cf);
            chk("div_zero", bus.div_zero, mx.dz);
            chk("latency_edge", ecnt, mx.en);
            chk("busy_cycles", busy_run, mx.bsy);
            l_ci = mx.ci; l_cf = mx.cf; l_dz = mx.dz;
         end
         busy_run = 0;
      end else begin
         if (bus.busy) busy_run++;
         chk("cpi_hold", {bus.cpi_int, bus.cpi_frac, bus.div_zero}, (l_ci << 9) | (l_cf << 1) | longint'(l_dz));
      end
   end
   initial begin
      bus.instr_retire = 0; bus.stall = 0; bus.clear = 0; bus.snapshot_req = 0;
      bus4.instr_retire = 0; bus4.stall = 0; bus4.clear = 0; bus4.snapshot_req = 0;
      #1 pc_rst = 1;
      #2;
      chk("rst_cycle", bus.cycle_count, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cpi_int", bus.cpi_int, 0);
      chk("rst_valid", bus.cpi_valid, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_div_zero", bus.div_zero, 0);
      @(posedge clk);
      @(posedge clk);
      #5 pc_rst = 0;
      mon_en = 1;
      for (int i = 0; i < 8; i++) step(i % 2 == 0, 0, 0, 0);
      step(0, 0, 0, 1);
      drain();
      chk("tp_8_4_int", bus.cpi_int, 2);
      chk("tp_8_4_frac", bus.cpi_frac, 8'h00);
      chk("tp_8_4_dz", bus.div_zero, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(i < 4, 0, 0, 0);
      step(0, 0, 0, 1);
      drain();
      chk("tp_10_4_frac", bus.cpi_frac, 8'h80);
      step(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(i < 3, 1, 0, 0);
      step(0, 0, 0, 1);
      drain();
      chk("tp_7_3_int", bus.cpi_int, 2);
      chk("tp_7_3_frac", bus.cpi_frac, 8'h55);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      drain();
      chk("tp_zero_dz", bus.div_zero, 1);
      chk("tp_zero_int", bus.cpi_int, 32'hFFFF_FFFF);
      chk("tp_zero_frac", bus.cpi_frac, 8'hFF);
      bus4.clear = 1;
      step(0, 0, 0, 0);
      bus4.clear = 0;
      bus4.instr_retire = 1;
      bus4.stall = 1;
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      chk("sat4_mid_cycle", bus4.cycle_count, 10);
      chk("sat4_mid_overflow", bus4.overflow, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      chk("sat4_cycle", bus4.cycle_count, 15);
      chk("sat4_instr", bus4.instr_count, 15);
      chk("sat4_stall", bus4.stall_count, 15);
      chk("sat4_overflow", bus4.overflow, 1);
      bus4.instr_retire = 0;
      bus4.stall = 0;
      bus4.clear = 1;
      step(0, 0, 0, 0);
      bus4.clear = 0;
      chk("clr4_cycle", bus4.cycle_count, 0);
      chk("clr4_instr", bus4.instr_count, 0);
      chk("clr4_overflow", bus4.overflow, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      #1 pc_rst = 1;
      m_cyc = 0; m_ins = 0; m_stl = 0; m_ovf = 0;
      q.delete();
      busy_run = 0;
      busy_until = -10;
      l_ci = 0; l_cf = 0; l_dz = 0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_cycle", bus.cycle_count, 0);
      chk("abort_instr", bus.instr_count, 0);
      chk("abort_cpi_int", bus.cpi_int, 0);
      chk("abort_cpi_frac", bus.cpi_frac, 0);
      chk("abort_div_zero", bus.div_zero, 0);
      #3 pc_rst = 0;
      for (int i = 0; i < 50; i++) step(i < 9, 0, 0, 0);
      step(0, 0, 0, 1);
      drain();
      step(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) step(i % 2 == 0, 0, 0, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      drain();
      step(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) step(i % 2 == 0, 0, 0, 0);
      step(0, 0, 1, 1);
      chk("clr_snap_cycle", bus.cycle_count, 0);
      drain();
      chk("clr_snap_int", bus.cpi_int, 2);
      chk("clr_snap_frac", bus.cpi_frac, 0);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
